// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared state encoding, blank pattern and anode helper for the scan mux.
package seg_scan_pkg;
  typedef enum logic [1:0] {IDLE, ON, GUARD} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [15:0] onehot_n(input logic [3:0] idx);
    return ~(16'd1 << idx);
  endfunction
endpackage

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: down-counter that reloads N-1 while idle and pulses tc on its last running cycle.
module seg_scan_tick #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tc
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  localparam logic [W-1:0] TOP = W'(N - 1);
  logic [W-1:0] cnt;
  assign tc = run && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= TOP;
    else cnt <= (!run || tc) ? TOP : cnt - 1'b1;
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: double-buffered 7-seg scanner with guard gaps between digits.
// Optional macro SEG_SCAN_MUX_DIM_EN adds a 4-bit PWM brightness input.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [NUM_DIGITS*8-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG_SCAN_MUX_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  import seg_scan_pkg::state_t;
  import seg_scan_pkg::IDLE;
  import seg_scan_pkg::ON;
  import seg_scan_pkg::SEG_BLANK;
  import seg_scan_pkg::onehot_n;

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int GW = GUARD > 0 ? GUARD : 1;

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, idx_nx, idx_inc;
  logic                    div_tc, guard_tc, last, frame, pending, lit, on_nx;
  logic [NUM_DIGITS*8-1:0] active, shadow, active_nx;
  logic [15:0]             an_full;

  seg_scan_tick #(.N(DIV)) u_div (
    .clk(clk), .rst_n(rst_n), .run(en && state == ON), .tc(div_tc)
  );
  seg_scan_tick #(.N(GW)) u_guard (
    .clk(clk), .rst_n(rst_n), .run(en && state == seg_scan_pkg::GUARD), .tc(guard_tc)
  );

  assign last    = idx == IW'(NUM_DIGITS - 1);
  assign idx_inc = last ? '0 : idx + 1'b1;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    frame    = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      idx_nx   = '0;
    end else if (state == IDLE) begin
      state_nx = ON;
      idx_nx   = '0;
    end else if (state == ON && div_tc) begin
      state_nx = (GUARD > 0) ? seg_scan_pkg::GUARD : ON;
      if (GUARD == 0) begin
        idx_nx = idx_inc;
        frame  = last;
      end
    end else if (state == seg_scan_pkg::GUARD && guard_tc) begin
      state_nx = ON;
      idx_nx   = idx_inc;
      frame    = last;
    end
  end

  assign frame_done = frame;
  // A load in IDLE or on the frame edge bypasses the shadow so the newest pattern wins.
  assign active_nx = (load && (state == IDLE || frame)) ? seg_in :
                     (frame && pending)                 ? shadow : active;

`ifdef SEG_SCAN_MUX_DIM_EN
  logic [3:0] pwm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm <= '0;
    else pwm <= pwm + 1'b1;
  assign lit = pwm < brightness;
`else
  assign lit = 1'b1;
`endif

  // Outputs are registered from next-state values so they line up with the state register.
  assign on_nx   = state_nx == ON && lit;
  assign an_full = onehot_n(4'(idx_nx));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      active  <= '1;
      shadow  <= '1;
      pending <= 1'b0;
      seg_out <= SEG_BLANK;
      an_out  <= '1;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      active  <= active_nx;
      if (load) shadow <= seg_in;
      pending <= load ? !(state == IDLE || frame) : pending && !frame;
      seg_out <= on_nx ? active_nx[idx_nx*8 +: 8] : SEG_BLANK;
      an_out  <= (on_nx && !blank_mask[idx_nx]) ? an_full[NUM_DIGITS-1:0] : '1;
    end
endmodule
